// File: rtl/div_operand_prep_if.sv
// Operand-pair handshake bus: upstream request side plus prepared-operand side
// toward the unsigned divider.
interface div_operand_prep_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_signed;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_dividend;
  logic [WIDTH-1:0] o_divisor;
  logic             o_neg_quot;
  logic             o_neg_rem;
  logic             o_div_zero;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_signed, i_ready,
    output o_ready, o_valid, o_dividend, o_divisor,
           o_neg_quot, o_neg_rem, o_div_zero, o_overflow
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_signed, i_ready,
    input  o_ready, o_valid, o_dividend, o_divisor,
           o_neg_quot, o_neg_rem, o_div_zero, o_overflow
  );
endinterface

// File: rtl/div_operand_prep.sv
// Converts signed/unsigned operand pairs into magnitudes plus sign/exception
// flags for an unsigned divider, buffered by a two-entry skid buffer.
module div_operand_prep #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  div_operand_prep_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             neg_quot;
    logic             neg_rem;
    logic             div_zero;
    logic             overflow;
  } entry_t;

  entry_t r_main, r_skid;
  logic   r_main_vld, r_skid_vld;

  entry_t w_new;
  logic   w_dd_neg, w_dv_neg;
  logic   w_in_xfer, w_out_xfer, w_main_free;

  // Flags and magnitudes are resolved at entry so the output side is pure storage
  always_comb begin
    w_new          = '0;
    w_dd_neg       = bus.i_signed & bus.i_dividend[WIDTH-1];
    w_dv_neg       = bus.i_signed & bus.i_divisor[WIDTH-1];
    w_new.dividend = w_dd_neg ? -bus.i_dividend : bus.i_dividend;
    w_new.divisor  = w_dv_neg ? -bus.i_divisor  : bus.i_divisor;
    w_new.div_zero = (bus.i_divisor == '0);
    w_new.neg_quot = bus.i_signed & (bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1])
                     & ~w_new.div_zero;
    w_new.neg_rem  = w_dd_neg;
    w_new.overflow = bus.i_signed
                     & (bus.i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     & (&bus.i_divisor);
  end

  assign w_in_xfer   = bus.i_valid & ~r_skid_vld;
  assign w_out_xfer  = r_main_vld & bus.i_ready;
  assign w_main_free = ~r_main_vld | w_out_xfer;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      // A full skid blocks input, so refilling from skid never races a new pair
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_in_xfer) begin
        r_main     <= w_new;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid     <= w_new;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.o_ready    = ~r_skid_vld;
  assign bus.o_valid    = r_main_vld;
  assign bus.o_dividend = r_main.dividend;
  assign bus.o_divisor  = r_main.divisor;
  assign bus.o_neg_quot = r_main.neg_quot;
  assign bus.o_neg_rem  = r_main.neg_rem;
  assign bus.o_div_zero = r_main.div_zero;
  assign bus.o_overflow = r_main.overflow;

endmodule

// File: tb/tb_div_operand_prep.sv
// Randomized bench for div_operand_prep with an arithmetic reference model
// and an ordered queue standing in for the buffer contents.
module tb_div_operand_prep;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  div_operand_prep_if #(.WIDTH(32)) bus ();

  div_operand_prep #(.WIDTH(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] dv;
    logic        nq;
    logic        nr;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers, take absolute values, derive flags
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint va, vb, ma, mb;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    ma = (va < 0) ? -va : va;
    mb = (vb < 0) ? -vb : vb;
    e.dd = ma[31:0];
    e.dv = mb[31:0];
    e.dz = (vb == 0);
    e.nq = s && ((va < 0) != (vb < 0)) && (vb != 0);
    e.nr = s && (va < 0);
    e.ov = s && (va == -64'sd2147483648) && (vb == -64'sd1);
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
      chk("rst_o_valid", bus.o_valid, 0);
      chk("rst_o_ready", bus.o_ready, 1);
      chk("rst_data", {bus.o_dividend, bus.o_divisor}, 0);
      chk("rst_flags", {bus.o_neg_quot, bus.o_neg_rem, bus.o_div_zero, bus.o_overflow}, 0);
    end else begin
      chk("o_valid", bus.o_valid, q.size() > 0);
      chk("o_ready", bus.o_ready, q.size() < 2);
      if (bus.o_valid && q.size() > 0) begin
        chk("o_dividend", bus.o_dividend, q[0].dd);
        chk("o_divisor",  bus.o_divisor,  q[0].dv);
        chk("flags", {bus.o_neg_quot, bus.o_neg_rem, bus.o_div_zero, bus.o_overflow},
            {q[0].nq, q[0].nr, q[0].dz, q[0].ov});
      end
      if (bus.o_valid && bus.i_ready && q.size() > 0) void'(q.pop_front());
      if (bus.i_valid && bus.o_ready)
        q.push_back(model(bus.i_signed, bus.i_dividend, bus.i_divisor));
    end
  end

  // Holds the pair until accepted; returns 1ns after the accepting edge
  task automatic push(input logic s, input logic [31:0] a, input logic [31:0] b);
    int   n = 0;
    logic acc = 1'b0;
    bus.i_signed   = s;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    bus.i_valid    = 1'b1;
    do begin
      @(negedge i_clk);
      acc = bus.o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 0, 1);
    bus.i_valid = 1'b0;
  endtask

  task automatic dchk(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] edd, input logic [31:0] edv, input logic [3:0] eflags);
    bus.i_ready = 1'b1;
    push(s, a, b);
    chk("lit_valid",    bus.o_valid, 1);
    chk("lit_dividend", bus.o_dividend, edd);
    chk("lit_divisor",  bus.o_divisor, edv);
    chk("lit_flags", {bus.o_neg_quot, bus.o_neg_rem, bus.o_div_zero, bus.o_overflow}, eflags);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] c[4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_signed   = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b0;

    // flags order: neg_quot, neg_rem, div_zero, overflow
    dchk(1'b0, 32'hF0F0_F0F0, 32'h0000_000F, 32'hF0F0_F0F0, 32'hF, 4'b0000);
    dchk(1'b1, 32'hFFFF_FF9C, 32'd7, 32'd100, 32'd7, 4'b1100);
    dchk(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 4'b0101);
    dchk(1'b1, 32'd12345, 32'd0, 32'd12345, 32'd0, 4'b0010);
    dchk(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0000);
    dchk(1'b1, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0, 4'b0110);
    repeat (3) @(posedge i_clk);
    #1;

    // Backpressure: A and B fill both entries, C must wait
    bus.i_ready = 1'b0;
    push(1'b0, 32'd1000, 32'd3);
    push(1'b0, 32'd2000, 32'd5);
    chk("bp_full_ready", bus.o_ready, 0);
    bus.i_signed   = 1'b0;
    bus.i_dividend = 32'd3000;
    bus.i_divisor  = 32'd7;
    bus.i_valid    = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("bp_c_blocked", bus.o_ready, 0);
      chk("bp_a_stable", bus.o_dividend, 32'd1000);
    end
    @(posedge i_clk);
    #1 bus.i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_a_first", bus.o_dividend, 32'd1000);
    push(1'b0, 32'd3000, 32'd7);
    repeat (4) @(posedge i_clk);
    #1;

    // Asynchronous reset with both entries occupied
    bus.i_ready = 1'b0;
    push(1'b1, 32'hFFFF_FFF0, 32'd3);
    push(1'b0, 32'd55, 32'd5);
    #1 i_rst = 1'b1;
    #1;
    chk("arst_o_valid", bus.o_valid, 0);
    chk("arst_o_ready", bus.o_ready, 1);
    chk("arst_data", bus.o_dividend, 0);
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    dchk(1'b0, 32'd100, 32'd10, 32'd100, 32'd10, 4'b0000);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge i_clk);
      #1;
      bus.i_ready    = ($urandom_range(0, 3) != 0);
      bus.i_valid    = $urandom_range(0, 1);
      bus.i_signed   = $urandom_range(0, 1);
      bus.i_dividend = rnd_op();
      bus.i_divisor  = rnd_op();
    end
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_operand_prep.md
DIV_OPERAND_PREP -- requirements
Module: div_operand_prep

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits (even, >= 4).
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_valid  input  1  upstream operand pair valid.
REQ-005 o_ready  output  1  block can accept an operand pair this cycle.
REQ-006 i_dividend  input  WIDTH  dividend, two's complement when i_signed=1, else unsigned.
REQ-007 i_divisor  input  WIDTH  divisor, same encoding as i_dividend.
REQ-008 i_signed  input  1  1 = signed division request, 0 = unsigned.
REQ-009 o_valid  output  1  prepared operands valid toward the unsigned divider.
REQ-010 i_ready  input  1  downstream accepts the prepared operands.
REQ-011 o_dividend  output  WIDTH  unsigned dividend magnitude.
REQ-012 o_divisor  output  WIDTH  unsigned divisor magnitude.
REQ-013 o_neg_quot  output  1  post-stage negates the quotient.
REQ-014 o_neg_rem  output  1  post-stage negates the remainder.
REQ-015 o_div_zero  output  1  divisor equals zero.
REQ-016 o_overflow  output  1  signed overflow (most-negative / -1).

Function
REQ-017 Input transfer SHALL occur on a rising edge when i_valid=1 and o_ready=1; output transfer SHALL occur when o_valid=1 and i_ready=1.
REQ-018 Storage SHALL be a two-entry skid buffer (main register driving the outputs, plus a skid register); o_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from i_ready.
REQ-019 Latency SHALL be one cycle: a pair accepted at edge N SHALL present o_valid=1 after edge N if the main register is empty or drains at edge N.
REQ-020 A pair accepted while the main register holds an undrained entry SHALL go to the skid register; when main drains and skid is valid, skid SHALL move to main at that same edge.
REQ-021 Order SHALL be preserved; no pair SHALL be dropped or duplicated.
REQ-022 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-023 Magnitude: if i_signed=1 and operand MSB=1, the magnitude SHALL be the two's-complement negation, otherwise the operand unchanged; the most-negative value SHALL map to 2^(WIDTH-1).
REQ-024 o_neg_quot SHALL be i_signed AND (dividend MSB XOR divisor MSB) AND NOT div_zero.
REQ-025 o_neg_rem SHALL be i_signed AND dividend MSB.
REQ-026 o_div_zero SHALL be 1 when i_divisor == 0 regardless of i_signed, and magnitudes SHALL still be passed through.
REQ-027 o_overflow SHALL be 1 only when i_signed=1, i_dividend = 1 followed by WIDTH-1 zeros, and i_divisor is all ones.
REQ-028 All flags and magnitudes SHALL be computed at input and stored with the entry, never recomputed at output.
REQ-029 When simultaneous input and output transfers occur with the skid register empty, the new pair SHALL load directly into main.

Reset
REQ-030 When i_rst=1, the block SHALL immediately clear both entries: o_valid=0, o_ready=1, all data and flag outputs 0.
REQ-031 When reset is asserted mid-operation, it SHALL discard any buffered entries; the first accept after deassertion SHALL behave as from empty.

Verification
REQ-032 Unsigned pass-through: i_signed=0, 0xF0F0F0F0 / 0x0000000F, i_ready=1 -> next cycle o_dividend=0xF0F0F0F0, o_divisor=0xF, all flags 0.
REQ-033 Signed mixed: i_signed=1, -100 (0xFFFFFF9C) / 7 -> o_dividend=100, o_divisor=7, o_neg_quot=1, o_neg_rem=1, o_div_zero=0, o_overflow=0.
REQ-034 Edge cases: i_signed=1, 0x80000000 / 0xFFFFFFFF -> o_dividend=0x80000000, o_divisor=1, o_overflow=1, o_neg_quot=0; separately, 12345 / 0 -> o_div_zero=1, o_neg_quot=0.
REQ-035 Backpressure: hold i_ready=0 and push pairs A, B -> o_ready=0 after B and a held pair C is not taken; raise i_ready -> A, B, C emerge in order, one per cycle, each held stable while stalled.
REQ-036 Reset mid-stream: two entries buffered, assert i_rst asynchronously between edges -> o_valid=0 and o_ready=1 immediately; after release, pair 100/10 emerges one cycle after acceptance.
